// File: rtl/fifo_bytes_pkg.sv
// Shared constants and helper types for the byte FIFO feeding the 8-bit register stage.
package fifo_bytes_pkg;

  // Word width shared with the downstream register stage
  localparam int unsigned FIFO_DATA_W = 8;
  // Default FIFO depth and matching pointer index width
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned FIFO_ADDR_W = 2;

  // Per-edge occupancy operation, encoded as {pop, push}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Classify the qualified handshakes of one edge into an occupancy operation
  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/fifo_bytes_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module fifo_bytes_mem
  import fifo_bytes_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; contents are deliberately not reset, pointers make stale words unreachable
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read of the entry at rd_addr
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_bytes.sv
// Show-ahead byte FIFO: pointer/count registers, flags, handshake gating and empty zero-mask.
module fifo_bytes
  import fifo_bytes_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  count_q;
  logic [DATA_W-1:0] rd_data;
  logic              push;
  logic              pop;
  fifo_op_e          op;

  // Flags come only from the registered pointers; the extra MSB separates full from empty
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign in_ready  = ~full;
  assign out_valid = ~empty;

  // Qualified handshakes; a full FIFO refuses writes even while popping
  assign push = in_valid & ~full;
  assign pop  = out_ready & ~empty;
  assign op   = fifo_op(push, pop);

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case (op)
        OP_PUSH: count_q <= count_q + PTR_W'(1);
        OP_POP:  count_q <= count_q - PTR_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count = count_q;

  fifo_bytes_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (in_data),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  // Head word is shown only while valid; stale storage never leaks out
  assign out_data = empty ? '0 : rd_data;

endmodule
